observer_scan: RTL and testbench
================================

# observer_scan

Debug scan controller that drives the `observer` block's `mode`/`reg_sel` inputs through a fixed sequence and streams every observed word out over a valid/ready interface. A single `start_i` pulse dumps all 16 general registers, ALU A, ALU B, ALU out, PC and IR. The block halts the CPU for the duration of the dump so that PC, IR and register contents stay consistent. It sits between `observer` and the debug/host link.

## Interface
- `DATA_W`, 32: width of observed data (`RegBus`).
- `SEL_W`, 4: width of the register select (`RegAddrBus`).
- `SETTLE`, 1: cycles `mode_o`/`reg_sel_o` are held before `data_i` is captured. Legal range 1..15.

Ports:
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: begin a dump; sampled only in IDLE.
- `abort_i`  in  1: terminate the dump in progress.
- `data_i`  in  DATA_W: `observer` `data_o`.
- `mode_o`  out  2: to `observer` `mode_i`.
- `reg_sel_o`  out  SEL_W: to `observer` `reg_sel_i`.
- `cpu_halt_o`  out  1: high in every state except IDLE.
- `dump_valid_o`  out  1: stream word valid.
- `dump_ready_i`  in  1: stream consumer ready.
- `dump_data_o`  out  DATA_W: captured word.
- `dump_tag_o`  out  2+SEL_W: {mode, sel} of the captured word.
- `dump_last_o`  out  1: high with index 20.
- `busy_o`  out  1: equal to `cpu_halt_o`.
- `done_o`  out  1: one-cycle pulse after a completed dump.

## Operation
- Scan index `idx` is 5 bits and runs 0..20 (21 words):
  - idx 0..15 → mode 2'b00, sel = idx.
  - idx 16..18 → mode 2'b01, sel 1, 2, 3 (ALU A, ALU B, ALU out).
  - idx 19..20 → mode 2'b11, sel 4'b1110 (PC), 4'b1111 (IR).
- `mode_o`/`reg_sel_o` are a registered decode of `idx`. They are updated on the same edge that `idx` changes.
- State IDLE:
  - Outputs `mode_o`=0, `reg_sel_o`=0, `idx`=0, no valid.
  - `start_i`=1 → SETUP; `settle_cnt` loaded with SETTLE-1.
- State SETUP:
  - `settle_cnt` decrements each cycle.
  - When it is 0: `data_i` is latched into `dump_data_o`, {mode_o, reg_sel_o} into `dump_tag_o`, and (idx==20) into `dump_last_o`; next state SEND.
- State SEND:
  - `dump_valid_o`=1.
  - On `dump_valid_o && dump_ready_i`:
    - If idx==20 → DONE.
    - Otherwise idx+1 → SETUP, with `settle_cnt` reloaded.
- State DONE: `done_o`=1 for exactly one cycle, then IDLE with `idx` cleared.
- `abort_i`=1 in SETUP, SEND or DONE:
  - Next state is IDLE; `idx`, `mode_o` and `reg_sel_o` are cleared.
  - `dump_valid_o` drops on the next edge. No `done_o`, and no handshake completes in that cycle even if `dump_ready_i` is high.
  - Abort takes priority over every other transition.
- `start_i` outside IDLE is ignored. `abort_i` in IDLE is ignored.
- If `start_i` and `abort_i` are both high in IDLE, the dump starts (abort only acts outside IDLE).

## Timing
- Reset values: state IDLE, `mode_o`=2'b00, `reg_sel_o`=0, `cpu_halt_o`=0, `busy_o`=0, `dump_valid_o`=0, `dump_data_o`=0, `dump_tag_o`=0, `dump_last_o`=0, `done_o`=0.
- Reset asserted mid-dump returns all outputs to these values immediately, without waiting for a clock edge.
- `cpu_halt_o` rises on the edge that samples `start_i` and falls on the edge leaving DONE or on an abort.
- Latency from `start_i` sampled at edge E:
  - First `dump_valid_o` is visible after edge E+SETTLE.
  - With `dump_ready_i` held high, each word takes SETTLE+1 cycles.
  - With SETTLE=1, `done_o` is high in cycle 42 after E (cycle-accurate), and the total dump is 43 cycles.
- Stream rules:
  - `dump_data_o`, `dump_tag_o` and `dump_last_o` stay stable while `dump_valid_o && !dump_ready_i`.
  - `dump_valid_o` never deasserts without a handshake, except on abort or reset.
- `data_i` is assumed combinationally valid SETTLE cycles after a select change. The `observer` path is combinational, so SETTLE=1 suffices.

## Test plan
- Reset with `start_i`=0 → all outputs 0 and stay 0 for 10 cycles.
- Register file preloaded with r[n]=0x1000+n, ALU A/B/O=0xA,0xB,0xC, PC=0x400, IR=0xDEADBEEF; `start_i` pulse, ready tied high →
  - 21 words in order 0x1000..0x100F, 0xA, 0xB, 0xC, 0x400, 0xDEADBEEF.
  - Tags 0x00..0x0F, 0x11, 0x12, 0x13, 0x3E, 0x3F.
  - `dump_last_o` only on the final word; `done_o` once; 43 cycles total.
- Backpressure: `dump_ready_i` random 30% duty → identical word/tag sequence, data held stable while stalled, `cpu_halt_o` high throughout.
- `abort_i` during SEND of idx 7 with ready low → valid drops next cycle, `busy_o`=0, no `done_o`; a new `start_i` restarts at idx 0.
- `start_i` pulsed during a dump → ignored, sequence unchanged. SETTLE=3 → each word spaced 4 cycles with ready high.
- `rst_n` asserted asynchronously mid-dump (idx 12) → outputs zero before the next edge; after release the block is in IDLE.

Source files
------------

// File: rtl/observer_scan.sv
// -----------------------------------------------------------------------------
// observer_scan
//
// Debug scan controller. Walks the observer's mode/reg_sel inputs through a
// fixed 21-entry sequence (r0..r15, ALU A, ALU B, ALU out, PC, IR), captures
// each observed word and streams it out over a valid/ready interface. The CPU
// is held halted for the whole dump so the captured state is self-consistent.
//
// Parameters:
//   DATA_W  width of observed data
//   SEL_W   width of the register select
//   SETTLE  cycles the select is held before data_i is captured (1..15)
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         begin a dump (sampled only when idle)
//   abort_i         terminate the dump in progress
//   data_i          observer data output
//   mode_o          observer mode select
//   reg_sel_o       observer register select
//   cpu_halt_o      CPU halt request, high whenever not idle
//   dump_valid_o    stream word valid
//   dump_ready_i    stream consumer ready
//   dump_data_o     captured word
//   dump_tag_o      {mode, sel} the captured word was taken with
//   dump_last_o     marks the final word (index 20)
//   busy_o          same as cpu_halt_o
//   done_o          one-cycle pulse after a completed dump
// -----------------------------------------------------------------------------
module observer_scan #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [1:0]        mode_o,
  output logic [SEL_W-1:0]  reg_sel_o,
  output logic              cpu_halt_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [SEL_W+1:0]  dump_tag_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int         TAG_W       = SEL_W + 2;
  localparam logic [4:0] LAST_IDX    = 5'd20;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Maps a scan index to the {mode, sel} pair presented to the observer.
  function automatic logic [TAG_W-1:0] scan_tag(input logic [4:0] i);
    logic [TAG_W-1:0] t;
    t = {TAG_W{1'b0}};
    if (i < 5'd16) begin
      t = {2'b00, SEL_W'(i[3:0])};
    end else begin
      case (i)
        5'd16:   t = {2'b01, SEL_W'(4'd1)};   // ALU A
        5'd17:   t = {2'b01, SEL_W'(4'd2)};   // ALU B
        5'd18:   t = {2'b01, SEL_W'(4'd3)};   // ALU out
        5'd19:   t = {2'b11, SEL_W'(4'hE)};   // PC
        5'd20:   t = {2'b11, SEL_W'(4'hF)};   // IR
        default: t = {TAG_W{1'b0}};
      endcase
    end
    return t;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [4:0]         idx_r;
  logic [4:0]         idx_s;
  logic [3:0]         settle_cnt_r;
  logic [3:0]         settle_cnt_s;
  logic [TAG_W-1:0]   sel_tag_r;
  logic [TAG_W-1:0]   sel_tag_s;
  logic               capture_s;

  logic [DATA_W-1:0]  dump_data_r;
  logic [TAG_W-1:0]   dump_tag_r;
  logic               dump_last_r;
  logic               dump_valid_r;
  logic               halt_r;
  logic               done_r;

  // Next-state, scan index and settle counter decode.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    settle_cnt_s = settle_cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Abort is meaningless here; start wins even if both are high.
        idx_s = 5'd0;
        if (start_i) begin
          state_s      = ST_SETUP;
          settle_cnt_s = SETTLE_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (abort_i) begin
          state_s = ST_IDLE;
          idx_s   = 5'd0;
        end else if (settle_cnt_r == 4'd0) begin
          capture_s = 1'b1;
          state_s   = ST_SEND;
        end else begin
          settle_cnt_s = settle_cnt_r - 4'd1;
        end
      end
      ST_SEND: begin
        // valid is always high in SEND, so ready alone completes a handshake.
        if (abort_i) begin
          state_s = ST_IDLE;
          idx_s   = 5'd0;
        end else if (dump_ready_i) begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_DONE;
          end else begin
            state_s      = ST_SETUP;
            idx_s        = idx_r + 5'd1;
            settle_cnt_s = SETTLE_LOAD;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        idx_s   = 5'd0;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 5'd0;
      end
    endcase
    // Select follows the index on the same edge the index changes.
    sel_tag_s = scan_tag(idx_s);
  end

  // Control state, scan index, settle counter and observer select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= 5'd0;
      settle_cnt_r <= 4'd0;
      sel_tag_r    <= {TAG_W{1'b0}};
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      settle_cnt_r <= settle_cnt_s;
      sel_tag_r    <= sel_tag_s;
    end
  end

  // Captured stream word; held untouched until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_data_r <= {DATA_W{1'b0}};
      dump_tag_r  <= {TAG_W{1'b0}};
      dump_last_r <= 1'b0;
    end else if (capture_s) begin
      // sel_tag_r is the select that has been settling, i.e. what data_i reflects.
      dump_data_r <= data_i;
      dump_tag_r  <= sel_tag_r;
      dump_last_r <= (idx_r == LAST_IDX);
    end else begin
      dump_data_r <= dump_data_r;
      dump_tag_r  <= dump_tag_r;
      dump_last_r <= dump_last_r;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_valid_r <= 1'b0;
      halt_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      dump_valid_r <= (state_s == ST_SEND);
      halt_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
    end
  end

  assign mode_o       = sel_tag_r[TAG_W-1:SEL_W];
  assign reg_sel_o    = sel_tag_r[SEL_W-1:0];
  assign cpu_halt_o   = halt_r;
  assign busy_o       = halt_r;
  assign dump_valid_o = dump_valid_r;
  assign dump_data_o  = dump_data_r;
  assign dump_tag_o   = dump_tag_r;
  assign dump_last_o  = dump_last_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_observer_scan.sv
// -----------------------------------------------------------------------------
// tb_observer_scan
//
// Directed bench for observer_scan. One instance uses SETTLE=1, a second uses
// SETTLE=3 for word-spacing checks. A small observer model supplies data_i as
// a function of mode/reg_sel.
// -----------------------------------------------------------------------------
module tb_observer_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i, dump_ready_i;
  logic [31:0] data_i;
  logic [1:0]  mode_o;
  logic [3:0]  reg_sel_o;
  logic        cpu_halt_o, dump_valid_o, dump_last_o, busy_o, done_o;
  logic [31:0] dump_data_o;
  logic [5:0]  dump_tag_o;

  logic        start3, abort3, ready3;
  logic [31:0] data3;
  logic [1:0]  mode3;
  logic [3:0]  sel3;
  logic        halt3, valid3, last3, busy3, done3;
  logic [31:0] ddata3;
  logic [5:0]  dtag3;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_data [21];
  logic [5:0]  exp_tag  [21];

  always #5 clk = ~clk;

  // Observer model: r[n]=0x1000+n, ALU A/B/O=A/B/C, PC=0x400, IR=DEADBEEF.
  function automatic logic [31:0] obs_model(input logic [1:0] m, input logic [3:0] s);
    case (m)
      2'b00: return 32'h0000_1000 + {28'd0, s};
      2'b01: begin
        case (s)
          4'd1:    return 32'h0000_000A;
          4'd2:    return 32'h0000_000B;
          4'd3:    return 32'h0000_000C;
          default: return 32'h0;
        endcase
      end
      2'b11: begin
        if (s == 4'hE) return 32'h0000_0400;
        else if (s == 4'hF) return 32'hDEAD_BEEF;
        else return 32'h0;
      end
      default: return 32'h0;
    endcase
  endfunction

  assign data_i = obs_model(mode_o, reg_sel_o);
  assign data3  = obs_model(mode3, sel3);

  observer_scan #(.DATA_W(32), .SEL_W(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .data_i(data_i), .mode_o(mode_o), .reg_sel_o(reg_sel_o),
    .cpu_halt_o(cpu_halt_o), .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i), .dump_data_o(dump_data_o),
    .dump_tag_o(dump_tag_o), .dump_last_o(dump_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  observer_scan #(.DATA_W(32), .SEL_W(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start3), .abort_i(abort3),
    .data_i(data3), .mode_o(mode3), .reg_sel_o(sel3),
    .cpu_halt_o(halt3), .dump_valid_o(valid3),
    .dump_ready_i(ready3), .dump_data_o(ddata3),
    .dump_tag_o(dtag3), .dump_last_o(last3),
    .busy_o(busy3), .done_o(done3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mode_o, reg_sel_o, cpu_halt_o, busy_o, dump_valid_o,
                dump_data_o, dump_tag_o, dump_last_o, done_o});
  endfunction

  // Full dump from IDLE; pct = ready duty in percent, poke = pulse start mid-dump.
  task automatic run_dump(input string name, input int pct, input bit poke, output int done_cyc);
    int          k;
    int          n_done;
    int          n_last;
    bit          r;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [5:0]  prev_tag;
    k = 0; n_done = 0; n_last = 0; done_cyc = -1; prev_stall = 1'b0;
    prev_data = 32'h0; prev_tag = 6'h0;
    start_i = 1'b1;
    dump_ready_i = (pct >= 100);
    tick();
    start_i = 1'b0;
    for (int cyc = 0; cyc < 800 && n_done == 0; cyc++) begin
      if (prev_stall) begin
        chk({name, "_stall_valid"}, 64'(dump_valid_o), 64'd1);
        chk({name, "_stall_data"}, 64'(dump_data_o), 64'(prev_data));
        chk({name, "_stall_tag"}, 64'(dump_tag_o), 64'(prev_tag));
      end
      chk({name, "_halt_busy"}, 64'({cpu_halt_o, busy_o}), 64'd3);
      if (done_o) begin
        n_done++;
        done_cyc = cyc;
      end
      r = (pct >= 100) ? 1'b1 : (int'($urandom_range(99, 0)) < pct);
      dump_ready_i = r;
      start_i = (poke && (cyc == 10 || cyc == 11));
      if (dump_valid_o && r) begin
        if (k < 21) begin
          chk({name, "_data"}, 64'(dump_data_o), 64'(exp_data[k]));
          chk({name, "_tag"}, 64'(dump_tag_o), 64'(exp_tag[k]));
          chk({name, "_last"}, 64'(dump_last_o), 64'(k == 20));
        end
        if (dump_last_o) n_last++;
        k++;
      end
      prev_stall = dump_valid_o && !r;
      prev_data  = dump_data_o;
      prev_tag   = dump_tag_o;
      tick();
    end
    start_i = 1'b0;
    chk({name, "_words"}, 64'(k), 64'd21);
    chk({name, "_done_cnt"}, 64'(n_done), 64'd1);
    chk({name, "_last_cnt"}, 64'(n_last), 64'd1);
    chk({name, "_end_idle"}, 64'({cpu_halt_o, busy_o, dump_valid_o, done_o}), 64'd0);
    dump_ready_i = 1'b0;
  endtask

  initial begin
    int dc;
    int k;
    bit found;
    for (int i = 0; i < 16; i++) begin
      exp_data[i] = 32'h0000_1000 + 32'(i);
      exp_tag[i]  = 6'(i);
    end
    exp_data[16] = 32'h0000_000A; exp_tag[16] = 6'h11;
    exp_data[17] = 32'h0000_000B; exp_tag[17] = 6'h12;
    exp_data[18] = 32'h0000_000C; exp_tag[18] = 6'h13;
    exp_data[19] = 32'h0000_0400; exp_tag[19] = 6'h3E;
    exp_data[20] = 32'hDEAD_BEEF; exp_tag[20] = 6'h3F;

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; dump_ready_i = 1'b0;
    start3 = 1'b0; abort3 = 1'b0; ready3 = 1'b1;

    // Reset state, then 10 idle cycles with start low.
    tick(); tick();
    chk("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_outs", all_outs(), 64'd0);
    end

    // Full dump with ready held high: done in cycle 42, 43 cycles total.
    run_dump("full", 100, 1'b0, dc);
    chk("full_done_cycle", 64'(dc), 64'd42);

    // Random backpressure at 30% ready duty.
    run_dump("bp", 30, 1'b0, dc);

    // Start pulsed mid-dump is ignored; timing unchanged.
    run_dump("poke", 100, 1'b1, dc);
    chk("poke_done_cycle", 64'(dc), 64'd42);

    // Abort while idx 7 is stalled in SEND.
    start_i = 1'b1; dump_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (dump_valid_o && dump_tag_o == 6'h07) found = 1'b1;
      else tick();
    end
    chk("abort_reach7", 64'(found), 64'd1);
    dump_ready_i = 1'b0;
    tick();
    chk("abort_stalled", 64'({dump_valid_o, dump_tag_o}), 64'({1'b1, 6'h07}));
    abort_i = 1'b1; dump_ready_i = 1'b1;
    tick();
    abort_i = 1'b0; dump_ready_i = 1'b0;
    chk("abort_state", 64'({dump_valid_o, busy_o, cpu_halt_o, done_o, mode_o, reg_sel_o}), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("abort_quiet", 64'({dump_valid_o, busy_o, done_o}), 64'd0);
    end
    run_dump("restart", 100, 1'b0, dc);
    chk("restart_done_cycle", 64'(dc), 64'd42);

    // start and abort together in IDLE: the dump starts, then abort acts.
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_abort_starts", 64'(cpu_halt_o), 64'd1);
    tick();
    abort_i = 1'b0;
    chk("start_abort_then_abort", 64'({cpu_halt_o, dump_valid_o}), 64'd0);
    tick();

    // SETTLE=3: first valid at cycle 3, then every 4 cycles; done at 84.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    k = 0; dc = -1;
    for (int cyc = 0; cyc < 200 && dc < 0; cyc++) begin
      if (valid3) begin
        if (k < 21) begin
          chk("s3_spacing", 64'(cyc), 64'(3 + 4 * k));
          chk("s3_data", 64'(ddata3), 64'(exp_data[k]));
        end
        k++;
      end
      if (done3) dc = cyc;
      else tick();
    end
    chk("s3_words", 64'(k), 64'd21);
    chk("s3_done_cycle", 64'(dc), 64'd84);
    tick();
    chk("s3_idle", 64'({halt3, valid3}), 64'd0);

    // Asynchronous reset while idx 12 is in SEND.
    start_i = 1'b1; dump_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (dump_valid_o && dump_tag_o == 6'h0C) found = 1'b1;
      else tick();
    end
    chk("rst_reach12", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", all_outs(), 64'd0);
    #2;
    rst_n = 1'b1;
    dump_ready_i = 1'b0;
    tick();
    chk("rst_after_idle", all_outs(), 64'd0);
    tick();
    chk("rst_after_idle2", 64'({cpu_halt_o, dump_valid_o, done_o}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
